// File: rtl/demux1to2_32bit_buf.sv
// Buffered 1-to-2 demultiplexer: one 32-bit input stream is steered by IN_SEL
// into one of two independent FIFOs, each drained through its own handshake.
module demux1to2_32bit_buf #(
    parameter int DEPTH = 2,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [31:0]     IN_DATA,
    input  logic            IN_SEL,
    input  logic            IN_VALID,
    output logic            IN_READY,
    output logic [31:0]     OUT1_DATA,
    output logic            OUT1_VALID,
    input  logic            OUT1_READY,
    output logic [CNTW-1:0] OUT1_COUNT,
    output logic [31:0]     OUT2_DATA,
    output logic            OUT2_VALID,
    input  logic            OUT2_READY,
    output logic [CNTW-1:0] OUT2_COUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    // Handshakes: a word moves on a rising edge only when valid && ready are both
    // high; IN_READY looks at IN_SEL and registered occupancy only, never at OUTk_READY.

    logic [1:0][DEPTH-1:0][31:0] mem_q, mem_d;
    logic [1:0][PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [1:0][PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [1:0][CNTW-1:0]        cnt_q, cnt_d;

    logic [1:0] full;
    logic [1:0] nonempty;
    logic [1:0] sel_oh;
    logic [1:0] out_ready;
    logic [1:0] push;
    logic [1:0] pop;

    assign sel_oh    = {IN_SEL, ~IN_SEL};
    assign out_ready = {OUT2_READY, OUT1_READY};

    always_comb begin
        full     = '0;
        nonempty = '0;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        for (int k = 0; k < 2; k++) begin
            full[k]     = (cnt_q[k] == FULL_CNT);
            nonempty[k] = (cnt_q[k] != '0);
        end

        // A full channel refuses the push even if it pops on the same edge.
        IN_READY = ~|(full & sel_oh);
        push     = sel_oh & {2{IN_VALID & IN_READY}};
        pop      = nonempty & out_ready;

        for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = IN_DATA;
                wr_ptr_d[k]           = wr_ptr_q[k] + PW'(1);
            end
            if (pop[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
            end
            case ({push[k], pop[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + CNTW'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - CNTW'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign OUT1_DATA  = mem_q[0][rd_ptr_q[0]];
    assign OUT1_VALID = nonempty[0];
    assign OUT1_COUNT = cnt_q[0];
    assign OUT2_DATA  = mem_q[1][rd_ptr_q[1]];
    assign OUT2_VALID = nonempty[1];
    assign OUT2_COUNT = cnt_q[1];

endmodule

// File: tb/tb_demux1to2_32bit_buf.sv
// Bench for demux1to2_32bit_buf: per-channel queue model checked every cycle,
// plus directed vectors with literal expectations.
module tb_demux1to2_32bit_buf;

    localparam int DEPTH = 2;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic [31:0]     IN_DATA = '0;
    logic            IN_SEL = 1'b0;
    logic            IN_VALID = 1'b0;
    logic            IN_READY;
    logic [31:0]     OUT1_DATA;
    logic            OUT1_VALID;
    logic            OUT1_READY = 1'b0;
    logic [CNTW-1:0] OUT1_COUNT;
    logic [31:0]     OUT2_DATA;
    logic            OUT2_VALID;
    logic            OUT2_READY = 1'b0;
    logic [CNTW-1:0] OUT2_COUNT;

    demux1to2_32bit_buf #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IN_DATA    (IN_DATA),
        .IN_SEL     (IN_SEL),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .OUT1_DATA  (OUT1_DATA),
        .OUT1_VALID (OUT1_VALID),
        .OUT1_READY (OUT1_READY),
        .OUT1_COUNT (OUT1_COUNT),
        .OUT2_DATA  (OUT2_DATA),
        .OUT2_VALID (OUT2_VALID),
        .OUT2_READY (OUT2_READY),
        .OUT2_COUNT (OUT2_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] exp1_q[$];
    logic [31:0] exp2_q[$];
    logic [31:0] sent2_q[$];
    logic [31:0] got2_q[$];
    logic        cap2 = 1'b0;
    int          max_cnt2 = 0;

    bit m_full1, m_full2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    // Model: a full channel takes no push; pops come from the head of each queue.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            exp1_q.delete();
            exp2_q.delete();
        end else begin
            if (cap2 && OUT2_VALID && OUT2_READY) got2_q.push_back(OUT2_DATA);
            m_full1 = (exp1_q.size() >= DEPTH);
            m_full2 = (exp2_q.size() >= DEPTH);
            if (OUT1_READY && exp1_q.size() != 0) void'(exp1_q.pop_front());
            if (OUT2_READY && exp2_q.size() != 0) void'(exp2_q.pop_front());
            if (IN_VALID && !IN_SEL && !m_full1) exp1_q.push_back(IN_DATA);
            if (IN_VALID && IN_SEL && !m_full2) exp2_q.push_back(IN_DATA);
        end
    end

    always @(negedge CLK) begin
        chk("cmp_valid1", 32'(OUT1_VALID), 32'(exp1_q.size() != 0));
        chk("cmp_count1", 32'(OUT1_COUNT), 32'(exp1_q.size()));
        if (exp1_q.size() != 0) chk("cmp_data1", OUT1_DATA, exp1_q[0]);
        chk("cmp_valid2", 32'(OUT2_VALID), 32'(exp2_q.size() != 0));
        chk("cmp_count2", 32'(OUT2_COUNT), 32'(exp2_q.size()));
        if (exp2_q.size() != 0) chk("cmp_data2", OUT2_DATA, exp2_q[0]);
        chk("cmp_in_ready", 32'(IN_READY),
            32'(IN_SEL ? (exp2_q.size() < DEPTH) : (exp1_q.size() < DEPTH)));
        if (int'(OUT2_COUNT) > max_cnt2) max_cnt2 = int'(OUT2_COUNT);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic tog;
        repeat (2) tick();
        chk("rst_valid1", 32'(OUT1_VALID), 32'd0);
        chk("rst_valid2", 32'(OUT2_VALID), 32'd0);
        chk("rst_ready",  32'(IN_READY),   32'd1);
        chk("rst_data1",  OUT1_DATA,       32'd0);
        RESET = 1'b0;

        // Fill both channels with two words, then reset mid-stream.
        IN_VALID = 1'b1; IN_SEL = 1'b0; IN_DATA = 32'h11; tick();
        IN_DATA = 32'h12; tick();
        IN_SEL = 1'b1; IN_DATA = 32'h21; tick();
        IN_DATA = 32'h22; tick();
        IN_VALID = 1'b0;
        chk("fill_cnt1", 32'(OUT1_COUNT), 32'd2);
        chk("fill_cnt2", 32'(OUT2_COUNT), 32'd2);
        chk("fill_ready_sel1", 32'(IN_READY), 32'd0);
        RESET = 1'b1;
        #1;
        chk("rstmid_valid1", 32'(OUT1_VALID), 32'd0);
        chk("rstmid_valid2", 32'(OUT2_VALID), 32'd0);
        chk("rstmid_cnt1",   32'(OUT1_COUNT), 32'd0);
        chk("rstmid_cnt2",   32'(OUT2_COUNT), 32'd0);
        chk("rstmid_ready",  32'(IN_READY),   32'd1);
        chk("rstmid_data1",  OUT1_DATA,       32'd0);
        chk("rstmid_data2",  OUT2_DATA,       32'd0);
        tick();
        RESET = 1'b0;
        IN_VALID = 1'b1; IN_SEL = 1'b0; IN_DATA = 32'hA5A5A5A5; tick();
        IN_VALID = 1'b0;
        chk("post_rst_data1",  OUT1_DATA,         32'hA5A5A5A5);
        chk("post_rst_valid1", 32'(OUT1_VALID),   32'd1);
        chk("post_rst_cnt1",   32'(OUT1_COUNT),   32'd1);
        OUT1_READY = 1'b1; tick();
        OUT1_READY = 1'b0;
        chk("post_rst_drain", 32'(OUT1_COUNT), 32'd0);

        // Routing and order with both consumers always ready.
        OUT1_READY = 1'b1; OUT2_READY = 1'b1;
        IN_VALID = 1'b1; IN_SEL = 1'b0; IN_DATA = 32'h1; tick();
        chk("route1_data1", OUT1_DATA, 32'h1);
        chk("route1_cnt1",  32'(OUT1_COUNT), 32'd1);
        IN_DATA = 32'h2; tick();
        chk("route2_data1", OUT1_DATA, 32'h2);
        IN_SEL = 1'b1; IN_DATA = 32'h3; tick();
        chk("route3_data2",  OUT2_DATA, 32'h3);
        chk("route3_valid1", 32'(OUT1_VALID), 32'd0);
        IN_SEL = 1'b0; IN_DATA = 32'h4; tick();
        chk("route4_data1",  OUT1_DATA, 32'h4);
        chk("route4_valid2", 32'(OUT2_VALID), 32'd0);
        IN_VALID = 1'b0; tick();
        chk("route5_valid1", 32'(OUT1_VALID), 32'd0);

        // Full stall on channel 1, then steer to channel 2.
        OUT1_READY = 1'b0; OUT2_READY = 1'b0;
        IN_VALID = 1'b1; IN_SEL = 1'b0; IN_DATA = 32'h10; tick();
        IN_DATA = 32'h11; tick();
        IN_DATA = 32'h12;
        chk("stall_cnt1",  32'(OUT1_COUNT), 32'd2);
        chk("stall_ready", 32'(IN_READY),   32'd0);
        tick();
        chk("stall_cnt1_hold", 32'(OUT1_COUNT), 32'd2);
        chk("stall_data1",     OUT1_DATA,       32'h10);
        IN_SEL = 1'b1; IN_DATA = 32'h20;
        #1;
        chk("stall_ready_sel1", 32'(IN_READY), 32'd1);
        tick();
        IN_VALID = 1'b0;
        chk("stall_data2",  OUT2_DATA,         32'h20);
        chk("stall_cnt2",   32'(OUT2_COUNT),   32'd1);
        chk("stall_cnt1_b", 32'(OUT1_COUNT),   32'd2);

        // Full channel with a pop in the same cycle: push waits one cycle.
        IN_VALID = 1'b1; IN_SEL = 1'b0; IN_DATA = 32'h30; OUT1_READY = 1'b1;
        #1;
        chk("fullpop_ready0", 32'(IN_READY), 32'd0);
        tick();
        chk("fullpop_cnt1a",  32'(OUT1_COUNT), 32'd1);
        chk("fullpop_data1a", OUT1_DATA,       32'h11);
        chk("fullpop_ready1", 32'(IN_READY),   32'd1);
        tick();
        chk("fullpop_cnt1b",  32'(OUT1_COUNT), 32'd1);
        chk("fullpop_data1b", OUT1_DATA,       32'h30);
        IN_VALID = 1'b0; tick();
        chk("fullpop_cnt1c", 32'(OUT1_COUNT), 32'd0);
        OUT1_READY = 1'b0; OUT2_READY = 1'b1; tick();
        OUT2_READY = 1'b0;
        chk("fullpop_cnt2", 32'(OUT2_COUNT), 32'd0);

        // Wrap-around: 20 words to channel 2 with a toggling consumer.
        cap2 = 1'b1;
        max_cnt2 = 0;
        tog = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int  guard;
            bit  done;
            guard = 0;
            done  = 1'b0;
            IN_VALID = 1'b1; IN_SEL = 1'b1; IN_DATA = 32'hC0DE0000 | 32'(i);
            sent2_q.push_back(IN_DATA);
            while (!done) begin
                OUT2_READY = tog;
                tog = ~tog;
                #1;
                done = IN_READY;
                tick();
                guard++;
                if (!done && guard > 10) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL wrap_accept_timeout: word %0d not accepted in %0d cycles", i, guard);
                    done = 1'b1;
                end
            end
        end
        IN_VALID = 1'b0; OUT2_READY = 1'b1;
        repeat (4) tick();
        cap2 = 1'b0;
        OUT2_READY = 1'b0;
        chk("wrap_len", 32'(got2_q.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < got2_q.size()) chk("wrap_word", got2_q[i], sent2_q[i]);
        end
        chk("wrap_max_le_depth", 32'(max_cnt2 <= DEPTH), 32'd1);
        chk("wrap_max_hit_depth", 32'(max_cnt2), 32'(DEPTH));

        // Pops against an empty channel are ignored.
        OUT1_READY = 1'b1;
        repeat (5) begin
            tick();
            chk("empty_cnt1", 32'(OUT1_COUNT), 32'd0);
        end
        IN_VALID = 1'b1; IN_SEL = 1'b0; IN_DATA = 32'h55; tick();
        IN_VALID = 1'b0;
        chk("empty_data1",  OUT1_DATA,       32'h55);
        chk("empty_valid1", 32'(OUT1_VALID), 32'd1);
        tick();
        chk("empty_final_cnt1", 32'(OUT1_COUNT), 32'd0);
        OUT1_READY = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
